ula_arbiter: RTL and testbench
==============================

Name: ula_arbiter

Overview:
Shares the single combinational RV32 ALU between two requesters: port 0 for the execute stage and port 1 for the address/branch helper path. Requests use valid/ready handshakes and are granted round-robin. The granted operation drives the ALU combinationally, and its result is captured in a one-entry registered response buffer. The block sits between decode/issue logic and the ALU; the ALU itself stays outside the block.

Parameters:
XLEN, 32, operand and result width (must match the ALU data width).
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  requester 0 operation accepted this cycle.
req0_opcode  input  7  RV opcode field.
req0_funct3  input  3  funct3 field.
req0_funct7  input  7  funct7 field.
req0_data1  input  XLEN  operand 1.
req0_data2  input  XLEN  operand 2.
req1_valid, req1_ready, req1_opcode, req1_funct3, req1_funct7, req1_data1, req1_data2  (same directions/widths as port 0)  requester 1.
alu_opcode  output  7  to ALU.
alu_funct3  output  3  to ALU.
alu_funct7  output  7  to ALU.
alu_data1  output  XLEN  to ALU.
alu_data2  output  XLEN  to ALU.
alu_result  input  XLEN  combinational ALU result.
rsp_valid  output  1  response buffer holds a result.
rsp_ready  input  1  consumer takes the response.
rsp_id  output  1  requester index that issued the result.
rsp_data  output  XLEN  registered ALU result.
op_count  output  CNT_W  number of accepted operations.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - rsp_valid=0, rsp_id=0, rsp_data=0, op_count=0.
  - Last-grant pointer=1, so port 0 wins the first tie.
  - Reset mid-operation discards any buffered response.
- can_accept = !rsp_valid || rsp_ready. The buffer may be refilled in the same cycle it drains (full throughput, one op/cycle).
- Grant (combinational), evaluated only when can_accept=1:
  - Only one port valid: that port is granted.
  - Both valid: the port other than the last-grant pointer is granted.
  - Neither valid: no grant.
- reqN_ready = can_accept && grantN. At most one ready is high per cycle. Ready never depends on the same port's ready.
- ALU drive: the granted port's opcode/funct3/funct7/data1/data2 are muxed to the alu_* outputs. With no grant, all alu_* outputs are 0.
- On an accept edge (some reqN_valid && reqN_ready):
  - rsp_data <= alu_result; rsp_id <= N; rsp_valid <= 1.
  - Last-grant pointer <= N.
  - op_count <= op_count+1, wrapping modulo 2^CNT_W.
- Latency: result is visible on rsp_data exactly 1 cycle after the accept edge.
- Drain without refill (rsp_valid && rsp_ready, no accept): rsp_valid <= 0. rsp_data and rsp_id hold their last values.
- Stall (rsp_valid && !rsp_ready): both readys are 0. rsp_valid, rsp_id and rsp_data are held stable. The pointer and op_count are unchanged.
- Requester obligation: fields must stay stable while valid && !ready. Arbitration is recomputed every cycle, so the grant is not sticky across stalls.
- The ALU opcode/funct encoding is not interpreted by this block. Unsupported ops pass through, and the ALU returns 0.

Test Plan:
- Reset: drive rst_n=0 for 2 edges with req0_valid=1 -> rsp_valid=0, op_count=0, req0_ready=0 during reset; first cycle after reset req0_ready=1.
- Single ADD: req0 opcode=0110011, f3=000, f7=0000000, data1=5, data2=7, ALU model attached -> req0_ready=1 in that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=12, op_count=1.
- Round-robin: both valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1 over 4 cycles; rsp_id sequence 0,1,0,1; op_count=4.
- Back-pressure: rsp_ready=0 after one accept, both requesters valid -> both readys 0; rsp_data held for 5 cycles. Raise rsp_ready -> drain and refill in the same edge; rsp_valid stays 1.
- Idle outputs: no request -> alu_opcode=0 and alu_data1=0; rsp_valid falls after drain.
- Counter wrap: CNT_W=4, 17 accepts -> op_count=1.

Source files
------------

// File: rtl/ula_arbiter.sv
// Round-robin sharing of one combinational RV32 ALU between two requesters,
// with a one-entry registered response buffer and an accepted-op counter.
module ula_arbiter #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [6:0]       req0_opcode,
   input  logic [2:0]       req0_funct3,
   input  logic [6:0]       req0_funct7,
   input  logic [XLEN-1:0]  req0_data1,
   input  logic [XLEN-1:0]  req0_data2,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [6:0]       req1_opcode,
   input  logic [2:0]       req1_funct3,
   input  logic [6:0]       req1_funct7,
   input  logic [XLEN-1:0]  req1_data1,
   input  logic [XLEN-1:0]  req1_data2,
   output logic [6:0]       alu_opcode,
   output logic [2:0]       alu_funct3,
   output logic [6:0]       alu_funct7,
   output logic [XLEN-1:0]  alu_data1,
   output logic [XLEN-1:0]  alu_data2,
   input  logic [XLEN-1:0]  alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [XLEN-1:0]  rsp_data,
   output logic [CNT_W-1:0] op_count
);

   logic             r_valid;
   logic             r_id;
   logic             r_ptr;
   logic [XLEN-1:0]  r_data;
   logic [CNT_W-1:0] r_cnt;

   logic w_can_accept;
   logic w_gnt0;
   logic w_gnt1;
   logic w_accept;

   // Nothing is accepted while reset is asserted.
   assign w_can_accept = rst_n & (~r_valid | rsp_ready);

   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (w_can_accept) begin
         if (req0_valid && req1_valid) begin
            w_gnt0 = r_ptr;
            w_gnt1 = ~r_ptr;
         end else begin
            w_gnt0 = req0_valid;
            w_gnt1 = req1_valid;
         end
      end
   end

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;
   assign w_accept   = w_gnt0 | w_gnt1;

   always_comb begin
      alu_opcode = '0;
      alu_funct3 = '0;
      alu_funct7 = '0;
      alu_data1  = '0;
      alu_data2  = '0;
      unique case (1'b1)
         w_gnt0: begin
            alu_opcode = req0_opcode;
            alu_funct3 = req0_funct3;
            alu_funct7 = req0_funct7;
            alu_data1  = req0_data1;
            alu_data2  = req0_data2;
         end
         w_gnt1: begin
            alu_opcode = req1_opcode;
            alu_funct3 = req1_funct3;
            alu_funct7 = req1_funct7;
            alu_data1  = req1_data1;
            alu_data2  = req1_data2;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_id    <= 1'b0;
         r_ptr   <= 1'b1;
         r_data  <= '0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_id    <= w_gnt1;
         r_ptr   <= w_gnt1;
         r_data  <= alu_result;
         r_cnt   <= r_cnt + CNT_W'(1);
      end else if (r_valid && rsp_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign rsp_valid = r_valid;
   assign rsp_id    = r_id;
   assign rsp_data  = r_data;
   assign op_count  = r_cnt;

endmodule

// File: tb/tb_ula_arbiter.sv
// Randomized and directed checks of ula_arbiter against a transaction-level
// model; a second instance with a 4-bit counter covers wrap-around.
module tb_ula_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        v0, v1, rsp_ready;
   logic [6:0]  op0, op1, f70, f71;
   logic [2:0]  f30, f31;
   logic [31:0] a0, b0, a1, b1;

   logic        rdy0, rdy1, rvalid, rid;
   logic [6:0]  aop, af7;
   logic [2:0]  af3;
   logic [31:0] ad1, ad2, rdata, alu_res;
   logic [15:0] cnt;

   logic        rdy0_4, rdy1_4, rvalid_4, rid_4;
   logic [6:0]  aop_4, af7_4;
   logic [2:0]  af3_4;
   logic [31:0] ad1_4, ad2_4, rdata_4;
   logic [3:0]  cnt_4;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(
      input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
      if (op != 7'b0110011) return 32'd0;
      case (f3)
         3'd0: return f7[5] ? a - b : a + b;
         3'd1: return a << b[4:0];
         3'd2: return {31'd0, $signed(a) < $signed(b)};
         3'd3: return {31'd0, a < b};
         3'd4: return a ^ b;
         3'd5: return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   assign alu_res = alu_f(aop, af3, af7, ad1, ad2);

   ula_arbiter #(.XLEN(32), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_ready(rdy0), .req0_opcode(op0),
      .req0_funct3(f30), .req0_funct7(f70),
      .req0_data1(a0), .req0_data2(b0),
      .req1_valid(v1), .req1_ready(rdy1), .req1_opcode(op1),
      .req1_funct3(f31), .req1_funct7(f71),
      .req1_data1(a1), .req1_data2(b1),
      .alu_opcode(aop), .alu_funct3(af3), .alu_funct7(af7),
      .alu_data1(ad1), .alu_data2(ad2), .alu_result(alu_res),
      .rsp_valid(rvalid), .rsp_ready(rsp_ready), .rsp_id(rid),
      .rsp_data(rdata), .op_count(cnt)
   );

   ula_arbiter #(.XLEN(32), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_ready(rdy0_4), .req0_opcode(op0),
      .req0_funct3(f30), .req0_funct7(f70),
      .req0_data1(a0), .req0_data2(b0),
      .req1_valid(v1), .req1_ready(rdy1_4), .req1_opcode(op1),
      .req1_funct3(f31), .req1_funct7(f71),
      .req1_data1(a1), .req1_data2(b1),
      .alu_opcode(aop_4), .alu_funct3(af3_4), .alu_funct7(af7_4),
      .alu_data1(ad1_4), .alu_data2(ad2_4), .alu_result(alu_res),
      .rsp_valid(rvalid_4), .rsp_ready(rsp_ready), .rsp_id(rid_4),
      .rsp_data(rdata_4), .op_count(cnt_4)
   );

   // Transaction-level model state
   bit        m_known = 0;
   bit        m_valid = 0;
   bit        m_id = 0;
   bit        m_ptr = 1;
   bit [31:0] m_data = 0;
   int        m_cnt = 0;
   bit        m_rdy0 = 0;
   bit        m_rdy1 = 0;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      int g;
      bit can;
      logic [80:0] exp_alu;
      @(negedge clk);
      g = -1;
      can = rst_n && (!m_valid || rsp_ready);
      if (can) begin
         if (v0 && v1) g = m_ptr ? 0 : 1;
         else if (v0) g = 0;
         else if (v1) g = 1;
      end
      m_rdy0 = (g == 0);
      m_rdy1 = (g == 1);
      chk("req0_ready", rdy0, m_rdy0);
      chk("req1_ready", rdy1, m_rdy1);
      if (g == 0) exp_alu = {op0, f30, f70, a0, b0};
      else if (g == 1) exp_alu = {op1, f31, f71, a1, b1};
      else exp_alu = '0;
      chk("alu_drive", {aop, af3, af7, ad1, ad2}, exp_alu);
      if (m_known) begin
         chk("rsp_valid", rvalid, m_valid);
         chk("rsp_id", rid, m_id);
         chk("rsp_data", rdata, m_data);
         chk("op_count", cnt, m_cnt % 65536);
         chk("op_count4", cnt_4, m_cnt % 16);
      end
      if (!rst_n) begin
         m_known = 1; m_valid = 0; m_id = 0;
         m_data = 0; m_ptr = 1; m_cnt = 0;
      end else if (g >= 0) begin
         m_data = (g == 0) ? alu_f(op0, f30, f70, a0, b0)
                           : alu_f(op1, f31, f71, a1, b1);
         m_id = (g == 1);
         m_ptr = (g == 1);
         m_valid = 1;
         m_cnt++;
      end else if (m_valid && rsp_ready) begin
         m_valid = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_fields(output logic [6:0] op, output logic [2:0] f3,
                             output logic [6:0] f7, output logic [31:0] a,
                             output logic [31:0] b);
      op = ($urandom_range(0, 3) != 0) ? 7'b0110011 : 7'($urandom);
      f3 = 3'($urandom);
      f7 = $urandom_range(0, 1) ? 7'b0100000 : 7'b0000000;
      a  = $urandom;
      b  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
   endtask

   initial begin
      logic [31:0] held;
      rst_n = 0; rsp_ready = 1;
      v0 = 1; v1 = 0;
      op0 = 7'b0110011; f30 = 0; f70 = 0; a0 = 5; b0 = 7;
      op1 = 0; f31 = 0; f71 = 0; a1 = 0; b1 = 0;
      step();
      step();
      chk("reset_rsp_valid", rvalid, 1'b0);
      chk("reset_op_count", cnt, 16'd0);

      rst_n = 1;
      step();
      chk("add_rsp_valid", rvalid, 1'b1);
      chk("add_rsp_id", rid, 1'b0);
      chk("add_rsp_data", rdata, 32'd12);
      chk("add_op_count", cnt, 16'd1);

      v1 = 1; op1 = 7'b0110011; f31 = 3'd4; a1 = 32'hF0F0; b1 = 32'h0FF0;
      repeat (4) step();
      chk("rr_op_count", cnt, 16'd5);

      rsp_ready = 0;
      step();
      held = rdata;
      repeat (5) step();
      chk("stall_hold", rdata, held);
      rsp_ready = 1;
      step();
      chk("refill_valid", rvalid, 1'b1);

      v0 = 0; v1 = 0;
      step();
      chk("idle_opcode", aop, 7'd0);
      chk("idle_data1", ad1, 32'd0);
      chk("drained", rvalid, 1'b0);

      v0 = 1;
      step();
      rst_n = 0;
      step();
      chk("midreset_valid", rvalid, 1'b0);
      rst_n = 1;

      for (int i = 0; i < 400; i++) begin
         if (!(v0 && !m_rdy0)) begin
            v0 = 1'($urandom_range(0, 1));
            rnd_fields(op0, f30, f70, a0, b0);
         end
         if (!(v1 && !m_rdy1)) begin
            v1 = 1'($urandom_range(0, 1));
            rnd_fields(op1, f31, f71, a1, b1);
         end
         rsp_ready = ($urandom_range(0, 9) < 7);
         step();
      end
      v0 = 0; v1 = 0; rsp_ready = 1;
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
